// File: rtl/rotl8_seq.sv
// Purpose: sequential left rotator, one bit position per clock; inverse of the 8-bit right rotator.
// Latency: result valid in_amt edges after the accept edge (same-cycle-after for in_amt=0).
// Backpressure: result and out_valid held stable in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - input handshake carrying in_data (word) and in_amt (left-rotate amount)
//   out_valid/out_ready   - output handshake carrying out_data (rotated word, registered)
//   busy                  - high while a word is in flight (SHIFT or DONE)
module rotl8_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, in_ready_q, busy_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_amt;
          // A zero amount needs no rotate step, so skip straight to the result.
          state_d = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        cnt_d  = cnt_q - AW'(1);
        // cnt_q counts remaining rotates including this one.
        if (cnt_q == AW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE; data is left untouched.
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign out_data  = data_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rotl8_seq.sv
module tb_rotl8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotl8_seq #(.WIDTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Reference rotations computed with plain integer arithmetic.
  function automatic logic [7:0] ref_rotl(input logic [7:0] d, input int n);
    int v;
    v = int'(d);
    return 8'(((v << n) | (v >> (8 - n))) & 255);
  endfunction

  function automatic logic [7:0] ref_rotr(input logic [7:0] d, input int n);
    int v;
    v = int'(d);
    return 8'(((v >> n) | (v << (8 - n))) & 255);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, measure latency, optional stall, handoff.
  task automatic xfer(input logic [7:0] d, input logic [2:0] n, input logic [7:0] exp,
                      input int stall, input string tag);
    int lat;
    lat = 0;
    chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = n;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_amt   = 3'($urandom);
    while (out_valid !== 1'b1 && lat < 12) begin
      if (in_ready !== 1'b0) chk({tag, " in_ready_shift"}, 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(n));
    chk({tag, " data"}, 32'(out_data), 32'(exp));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " popcount"}, 32'($countones(out_data)), 32'($countones(d)));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, " held_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " held_data"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " handoff_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " handoff_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] rin;

    // Reset held two cycles with random traffic on the inputs.
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b0;
    repeat (2) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'h00);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();

    // Directed amounts.
    xfer(8'h5A, 3'd0, 8'h5A, 0, "amt0");
    xfer(8'h81, 3'd1, 8'h03, 0, "amt1");
    xfer(8'hB4, 3'd3, 8'hA5, 1, "amt3");
    xfer(8'h01, 3'd7, 8'h80, 0, "amt7");

    // Backpressure with a competing word presented while busy.
    in_valid = 1'b1; in_data = 8'h0F; in_amt = 3'd4; out_ready = 1'b0;
    tick();
    in_data = 8'hAA; in_amt = 3'd1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd4);
    chk("bp data", 32'(out_data), 32'hF0);
    repeat (5) begin
      tick();
      chk("bp held_valid", 32'(out_valid), 32'd1);
      chk("bp held_data", 32'(out_data), 32'hF0);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp handoff_valid", 32'(out_valid), 32'd0);
    chk("bp handoff_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp no_accept busy", 32'(busy), 32'd0);
    chk("bp no_accept data", 32'(out_data), 32'hF0);

    // Reset during the third SHIFT cycle discards the word.
    in_valid = 1'b1; in_data = 8'hC3; in_amt = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst data", 32'(out_data), 32'h00);
    chk("mid rst busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (10) begin
      tick();
      chk("mid no_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    xfer(8'h12, 3'd2, 8'h48, 0, "post_rst");

    // Round trip through the right rotator for every word and amount.
    for (int d = 0; d < 256; d++) begin
      for (int n = 0; n < 8; n++) begin
        rin = ref_rotr(8'(d), n);
        xfer(rin, 3'(n), 8'(d), int'($urandom_range(0, 2)),
             $sformatf("rt d=%0h n=%0d", d, n));
      end
    end

    // Sanity of the reference itself against a known pair.
    rin = ref_rotl(8'hB4, 3);
    xfer(8'hB4, 3'd3, rin, 0, "ref_cross");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotl8_seq.md
# rotl8_seq

Sequential 8-bit left rotator with valid/ready handshakes on both sides. It undoes the 8-bit combinational right rotator. For every data `D` and amount `n`, feeding the right rotator's output for (`D`, `n`) into this block with the same `n` returns `D`. The block rotates one bit position per clock, so it trades latency for area. It sits on the decode side of the datapath, between the scrambled-word source and the consumer.

## Interface
- `WIDTH`, 8, data width; fixed at 8 for this release.
- `AW`, 3, rotate-amount width; log2(`WIDTH`).
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low; sampled on the `clk` rising edge and has priority over all other inputs.
- `in_valid` input 1: upstream presents `in_data`/`in_amt`.
- `in_ready` output 1: block can accept; high only in IDLE.
- `in_data` input 8: word to rotate.
- `in_amt` input 3: left-rotate amount, 0..7.
- `out_valid` output 1: `out_data` holds a finished result.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output 8: rotated word, registered.
- `busy` output 1: high in SHIFT or DONE.

## Operation
- Internal registers: `data_r[7:0]`, `cnt_r[2:0]`, and state in {IDLE, SHIFT, DONE}.
- `out_data` = `data_r`, `out_valid` = (state==DONE), `in_ready` = (state==IDLE), `busy` = (state!=IDLE).
- IDLE, with `in_valid`=1 (accept):
  - `data_r`<=`in_data`, `cnt_r`<=`in_amt`.
  - Next state is DONE if `in_amt`==0, else SHIFT.
- SHIFT, each cycle:
  - `data_r`<={`data_r[6:0]`,`data_r[7]`}, `cnt_r`<=`cnt_r`-1.
  - When `cnt_r`==1 (the last rotate), next state is DONE.
- DONE:
  - `data_r` holds.
  - If `out_ready`=1, next state is IDLE; otherwise stay in DONE.
- Rotation is modulo 8. The amount is 3 bits, so no out-of-range case exists. Bits are never lost: popcount(`out_data`) == popcount(`in_data`).
- `in_valid` in SHIFT/DONE is ignored. `in_ready`=0 there, so upstream must hold its data until IDLE.
- Unused state encoding: next state is IDLE and `data_r` is unchanged.

## Timing
- Reset values, applied at the first rising edge with `rst_n`=0:
  - state=IDLE, `data_r`=0x00, `cnt_r`=0.
  - Outputs: `out_valid`=0, `out_data`=0x00, `busy`=0, `in_ready`=1.
- Latency: accept edge E0, then `out_valid`=1 from the edge E0+`in_amt` onward.
  - `in_amt`=0: valid the cycle right after acceptance.
  - `in_amt`=7: valid 7 edges after acceptance.
- Result handoff: happens on the first edge with `out_valid`=1 and `out_ready`=1. `in_ready` rises the cycle after.
- No same-cycle result handoff plus new accept. Peak throughput is one word per `in_amt`+2 cycles.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` is stable and `out_valid` stays high indefinitely.
- `out_ready` held high permanently: each result is valid for exactly one cycle.
- Reset mid-operation, `rst_n`=0 in SHIFT or DONE:
  - At that edge the block returns to IDLE with `data_r`=0x00.
  - Any partial or pending result is discarded and no `out_valid` is produced for it.
- Reset and `in_valid` in the same cycle: reset wins and nothing is accepted.

## Test plan
- Reset: hold `rst_n`=0 two cycles with random inputs toggling -> `out_valid`=0, `out_data`=0x00, `busy`=0, `in_ready`=1.
- Zero amount: `in_data`=0x5A, `in_amt`=0 accepted -> next cycle `out_valid`=1, `out_data`=0x5A, `busy`=1.
- Single step and odd amount:
  - 0x81 with amt 1 -> `out_data`=0x03, `out_valid` rising 1 edge after the accept edge.
  - 0xB4 with amt 3 -> 0xA5 at 3 edges after.
  - 0x01 with amt 7 -> 0x80 at 7 edges after.
- Backpressure and ignored input:
  - 0x0F with amt 4 and `out_ready`=0 for 5 cycles -> `out_data`=0xF0 stable, `out_valid` held, `in_ready`=0.
  - A second `in_valid` word presented meanwhile is not accepted.
  - Raise `out_ready` -> one-cycle handoff, then IDLE.
- Reset mid-shift: accept 0xC3 with amt 6, assert `rst_n`=0 on the 3rd SHIFT cycle -> IDLE, `out_data`=0x00, no `out_valid` ever for that word. A fresh 0x12 with amt 2 afterward -> 0x48.
- Round trip: for all 256 `D` × 8 `n`, drive the 8-bit right rotator's output for (`D`, `n`) with `n` into the block, `out_ready` random -> `out_data`==`D` every time, and the latency checks above hold.
